// File: rtl/rgb_scheduler.sv
// Button-driven RGB scheduler: synchronised, debounced buttons queue colour requests that are
// granted round-robin and shown for a fixed hold time, followed by a dark gap. Define RGB_PWM_EN to dim the shown colour.
module rgb_scheduler #(
    parameter int DB_CYCLES   = 16,
    parameter int HOLD_CYCLES = 1000,
    parameter int GAP_CYCLES  = 100,
    parameter int DUTY        = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_red,
    input  logic       button_green,
    input  logic       button_blue,
    input  logic       button_yellow,
    output logic       led_red,
    output logic       led_green,
    output logic       led_blue,
    output logic       busy,
    output logic [3:0] pending,
    output logic [1:0] grant_id
);

    localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_C  = (MAX_HG > DB_CYCLES) ? MAX_HG : DB_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    leds;
    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    level;
    logic [3:0]    rise;
    logic [3:0]    clear;
    logic [CW-1:0] db_cnt [4];
    logic          found;
    logic [1:0]    pick;
    logic [1:0]    idx;
    logic          pwm_on;

    assign raw = {button_yellow, button_blue, button_green, button_red};
    assign {led_red, led_green, led_blue} = leds;

    function automatic logic [2:0] colour_of(input logic [1:0] id);
        case (id)
            2'd0:    colour_of = 3'b100;
            2'd1:    colour_of = 3'b010;
            2'd2:    colour_of = 3'b001;
            default: colour_of = 3'b101;
        endcase
    endfunction

    // A rising edge is flagged on the same cycle the debounced level flips to 1.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            rise[i] = sync2[i] & ~level[i] & (db_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        level[i]  <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Round-robin search starting just after the last grant.
    always_comb begin
        found = 1'b0;
        pick  = grant_id;
        idx   = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = grant_id + 2'(k + 1);
            if (!found && pending[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        clear = '0;
        if (state == IDLE && found) begin
            clear[pick] = 1'b1;
        end
    end

`ifdef RGB_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    assign pwm_on = (int'(pwm_cnt) < DUTY);
`else
    assign pwm_on = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            leds     <= '0;
            busy     <= 1'b0;
            pending  <= '0;
            grant_id <= 2'd3;
        end else begin
            // New requests are OR-ed in after the grant clear so a same-cycle set wins.
            pending <= (pending & ~clear) | rise;
            case (state)
                IDLE: begin
                    leds <= '0;
                    if (found) begin
                        grant_id <= pick;
                        state    <= SHOW;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        leds     <= colour_of(pick) & {3{pwm_on}};
                    end
                end
                SHOW: begin
                    if (cnt == HOLD_LAST) begin
                        state <= GAP;
                        cnt   <= '0;
                        leds  <= '0;
                    end else begin
                        cnt  <= cnt + CW'(1);
                        leds <= colour_of(grant_id) & {3{pwm_on}};
                    end
                end
                GAP: begin
                    leds <= '0;
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    leds  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_scheduler.sv
// Directed bench for rgb_scheduler with DB=4, HOLD=10, GAP=3; with RGB_PWM_EN it runs a
// dimmed blue show (HOLD=512, DUTY=64) instead.
module tb_rgb_scheduler;

    localparam int DB   = 4;
    localparam int GAP  = 3;
`ifdef RGB_PWM_EN
    localparam int HOLD = 512;
    localparam int DUTY = 64;
`else
    localparam int HOLD = 10;
    localparam int DUTY = 128;
`endif

    logic       clk;
    logic       rst;
    logic       button_red;
    logic       button_green;
    logic       button_blue;
    logic       button_yellow;
    logic       led_red;
    logic       led_green;
    logic       led_blue;
    logic       busy;
    logic [3:0] pending;
    logic [1:0] grant_id;

    rgb_scheduler #(
        .DB_CYCLES  (DB),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .DUTY       (DUTY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .button_red   (button_red),
        .button_green (button_green),
        .button_blue  (button_blue),
        .button_yellow(button_yellow),
        .led_red      (led_red),
        .led_green    (led_green),
        .led_blue     (led_blue),
        .busy         (busy),
        .pending      (pending),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [2:0] leds;
    assign leds = {led_red, led_green, led_blue};

    // Monitor: counts lit/busy cycles and records each dark-to-lit transition.
    logic [2:0] prev_leds = '0;
    int on_cnt   = 0;
    int busy_cnt = 0;
    int blue_cnt = 0;
    int rg_cnt   = 0;
    logic [2:0] show_col [$];
    logic [1:0] show_gid [$];

    always @(negedge clk) begin
        prev_leds <= leds;
        if (leds != 3'b000 && prev_leds == 3'b000) begin
            show_col.push_back(leds);
            show_gid.push_back(grant_id);
        end
        on_cnt   <= on_cnt + ((leds != 3'b000) ? 1 : 0);
        busy_cnt <= busy_cnt + (busy ? 1 : 0);
        blue_cnt <= blue_cnt + (led_blue ? 1 : 0);
        rg_cnt   <= rg_cnt + ((led_red | led_green) ? 1 : 0);
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(2);
    endtask

    int base_on, base_busy, base_show, base_blue, base_rg;
    logic [3:0] acc;

    initial begin
        rst = 1'b1;
        button_red = 1'b0;
        button_green = 1'b0;
        button_blue = 1'b0;
        button_yellow = 1'b0;
        ticks(3);
        check("rst_leds", 32'(leds), 32'(3'b000));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_grant", 32'(grant_id), 32'd3);
        rst = 1'b0;
        ticks(2);

`ifdef RGB_PWM_EN
        base_blue = blue_cnt;
        base_rg   = rg_cnt;
        button_blue = 1'b1;
        ticks(5);
        button_blue = 1'b0;
        ticks(2);
        check("pwm_grant", 32'(grant_id), 32'd2);
        ticks(540);
        check("pwm_blue_on", 32'(blue_cnt - base_blue), 32'd128);
        check("pwm_rg_off", 32'(rg_cnt - base_rg), 32'd0);
        check("pwm_busy_end", 32'(busy), 32'd0);
`else
        // Single clean red press
        base_on   = on_cnt;
        base_busy = busy_cnt;
        base_show = show_col.size();
        button_red = 1'b1;
        ticks(5);
        check("red_pend_early", 32'(pending), 32'h0);
        ticks(1);
        check("red_pend_set", 32'(pending), 32'h1);
        check("red_leds_pre", 32'(leds), 32'(3'b000));
        ticks(1);
        check("red_leds_on", 32'(leds), 32'(3'b100));
        check("red_busy", 32'(busy), 32'd1);
        check("red_grant", 32'(grant_id), 32'd0);
        check("red_pend_clr", 32'(pending), 32'h0);
        ticks(13);
        button_red = 1'b0;
        ticks(20);
        check("red_on_cycles", 32'(on_cnt - base_on), 32'd10);
        check("red_busy_cycles", 32'(busy_cnt - base_busy), 32'd13);
        check("red_show_count", 32'(show_col.size() - base_show), 32'd1);
        if (show_col.size() > base_show)
            check("red_show_col", 32'(show_col[base_show]), 32'(3'b100));
        check("red_pend_end", 32'(pending), 32'h0);

        // Two-cycle glitch on green
        base_on = on_cnt;
        acc = '0;
        button_green = 1'b1;
        ticks(2);
        button_green = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ticks(1);
            acc = acc | pending;
        end
        check("glitch_pending", 32'(acc), 32'h0);
        check("glitch_leds", 32'(on_cnt - base_on), 32'd0);

        // Red, green, yellow together
        do_reset();
        base_show = show_col.size();
        button_red = 1'b1;
        button_green = 1'b1;
        button_yellow = 1'b1;
        ticks(6);
        check("rgy_pending", 32'(pending), 32'hB);
        ticks(1);
        check("rgy_pend_after", 32'(pending), 32'hA);
        button_red = 1'b0;
        button_green = 1'b0;
        button_yellow = 1'b0;
        ticks(50);
        check("rgy_show_count", 32'(show_col.size() - base_show), 32'd3);
        if (show_col.size() >= base_show + 3) begin
            check("rgy_col0", 32'(show_col[base_show]), 32'(3'b100));
            check("rgy_gid0", 32'(show_gid[base_show]), 32'd0);
            check("rgy_col1", 32'(show_col[base_show+1]), 32'(3'b010));
            check("rgy_gid1", 32'(show_gid[base_show+1]), 32'd1);
            check("rgy_col2", 32'(show_col[base_show+2]), 32'(3'b101));
            check("rgy_gid2", 32'(show_gid[base_show+2]), 32'd3);
        end
        check("rgy_pend_end", 32'(pending), 32'h0);

        // Red re-pressed during its own show, blue waiting
        do_reset();
        base_show = show_col.size();
        button_red = 1'b1;
        button_blue = 1'b1;
        ticks(5);
        button_red = 1'b0;
        button_blue = 1'b0;
        ticks(6);
        button_red = 1'b1;
        ticks(20);
        button_red = 1'b0;
        ticks(40);
        check("rr_show_count", 32'(show_col.size() - base_show), 32'd3);
        if (show_col.size() >= base_show + 3) begin
            check("rr_col0", 32'(show_col[base_show]), 32'(3'b100));
            check("rr_gid0", 32'(show_gid[base_show]), 32'd0);
            check("rr_col1", 32'(show_col[base_show+1]), 32'(3'b001));
            check("rr_gid1", 32'(show_gid[base_show+1]), 32'd2);
            check("rr_col2", 32'(show_col[base_show+2]), 32'(3'b100));
            check("rr_gid2", 32'(show_gid[base_show+2]), 32'd0);
        end

        // Reset in the middle of a show
        do_reset();
        button_red = 1'b1;
        button_blue = 1'b1;
        ticks(5);
        button_red = 1'b0;
        button_blue = 1'b0;
        ticks(2);
        check("mid_pend_blue", 32'(pending), 32'h4);
        check("mid_leds_red", 32'(leds), 32'(3'b100));
        ticks(4);
        rst = 1'b1;
        ticks(1);
        check("mid_rst_leds", 32'(leds), 32'(3'b000));
        check("mid_rst_pend", 32'(pending), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_grant", 32'(grant_id), 32'd3);
        rst = 1'b0;
        base_on   = on_cnt;
        base_show = show_col.size();
        ticks(40);
        check("mid_no_shows", 32'(show_col.size() - base_show), 32'd0);
        check("mid_no_leds", 32'(on_cnt - base_on), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
